// File: rtl/dma_rd_pkg.sv
// Shared constants for the DMA read-response forwarding path: default
// parameter values, head field positions and the forwarder FSM encoding.
package dma_rd_pkg;

  // Default parameter values
  localparam int DEF_DATA_W  = 256;
  localparam int DEF_HEAD_W  = 128;
  localparam int DEF_TAG_W   = 6;
  localparam int DEF_CHNL_W  = 8;
  localparam int DEF_DWLEN_W = 11;
  localparam int DEF_MISC_W  = 12;
  localparam int DEF_LEN_W   = 13;
  localparam int DEF_Q_DEPTH = 4;

  // Head field layout. The last-of-request flag sits in the top bit and the
  // channel directly below it, so both are placed relative to HEAD_W.
  localparam int HEAD_LAST_OFS = 1;   // head[HEAD_W-1]
  localparam int HEAD_CHNL_OFS = 2;   // head[HEAD_W-2 -: HEAD_CHNL_W]
  localparam int HEAD_CHNL_W   = 7;
  localparam int HEAD_ADDR_LSB = 32;
  localparam int HEAD_ADDR_W   = 7;
  localparam int HEAD_LEN_LSB  = 0;

  // Descriptor misc field: [11:5] address low bits, [4:0] empty bytes
  localparam int MISC_ADDR_LSB = 5;
  localparam int MISC_EMPTY_W  = 5;

  // A DW count of zero encodes the maximum request of 1024 DW
  localparam int MAX_BYTES = 4096;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_FORWARD = 1'b1
  } fwd_state_e;

endpackage

// File: rtl/sub_req_rsp_skid.sv
// Two-entry output stage. Its full flag comes straight from a register, so
// the downstream ready never reaches the upstream read enable
// combinationally, while one entry of slack keeps 1 beat/cycle throughput.
module sub_req_rsp_skid #(
  parameter int PAYLOAD_W = 385
) (
  input  logic                 dma_clk,
  input  logic                 rst_n,
  input  logic                 push_valid,
  input  logic [PAYLOAD_W-1:0] push_payload,
  output logic                 full,
  output logic                 pop_valid,
  output logic [PAYLOAD_W-1:0] pop_payload,
  input  logic                 pop_ready
);

  logic       wr_sel_reg;
  logic       rd_sel_reg;
  logic [1:0] cnt_reg;
  logic       push;
  logic       pop;

  assign full      = (cnt_reg == 2'd2);
  assign pop_valid = (cnt_reg != 2'd0);
  assign push      = push_valid & ~full;
  assign pop       = pop_valid & pop_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [PAYLOAD_W-1:0] entry_reg;
      // Capture a pushed beat into the slot selected by the write pointer
      always_ff @(posedge dma_clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (push && (wr_sel_reg == 1'(gi))) begin
          entry_reg <= push_payload;
        end
      end
    end
  endgenerate

  // Present the oldest entry; zero when empty so idle outputs stay quiet
  always_comb begin
    pop_payload = '0;
    if (pop_valid) begin
      pop_payload = rd_sel_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge dma_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel_reg <= 1'b0;
      rd_sel_reg <= 1'b0;
      cnt_reg    <= 2'd0;
    end else begin
      if (push) wr_sel_reg <= ~wr_sel_reg;
      if (pop)  rd_sel_reg <= ~rd_sel_reg;
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + 2'd1;
        2'b01:   cnt_reg <= cnt_reg - 2'd1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

endmodule

// File: rtl/sub_req_rsp_fwd.sv
// Sub-request response forwarder: queues completed-tag descriptors, fetches
// each tag's beats from the reorder buffer in order, attaches a head word
// and streams the beats out through a two-entry skid stage.
module sub_req_rsp_fwd
  import dma_rd_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int HEAD_W  = DEF_HEAD_W,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int CHNL_W  = DEF_CHNL_W,
  parameter int DWLEN_W = DEF_DWLEN_W,
  parameter int MISC_W  = DEF_MISC_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int Q_DEPTH = DEF_Q_DEPTH
) (
  input  logic               dma_clk,
  input  logic               rst_n,
  output logic               ft_rd_rsp_ren,
  output logic [TAG_W-1:0]   ft_rd_rsp_tag,
  input  logic [DATA_W-1:0]  ft_rd_rsp_data,
  input  logic               ft_rd_rsp_last,
  input  logic               ft_rd_rsp_vld,
  input  logic               nxt_match_valid,
  output logic               nxt_match_ready,
  input  logic               nxt_match_last,
  input  logic [DWLEN_W-1:0] nxt_match_sz,
  input  logic [MISC_W-1:0]  nxt_match_misc,
  input  logic [CHNL_W-1:0]  nxt_match_chnl,
  input  logic [TAG_W-1:0]   nxt_match_tag,
  output logic               st_sub_req_rsp_valid,
  output logic               st_sub_req_rsp_last,
  output logic [DATA_W-1:0]  st_sub_req_rsp_data,
  output logic [HEAD_W-1:0]  st_sub_req_rsp_head,
  input  logic               st_sub_req_rsp_ready,
  output logic               beat_err
);

  localparam int Q_AW       = $clog2(Q_DEPTH);
  localparam int BEAT_BYTES = DATA_W / 8;
  localparam int BEAT_SH    = $clog2(BEAT_BYTES);
  localparam int PAYLOAD_W  = DATA_W + HEAD_W + 1;

  // Descriptor queue storage (no reset: contents only matter once counted)
  logic [TAG_W-1:0]       q_tag   [Q_DEPTH];
  logic [CHNL_W-1:0]      q_chnl  [Q_DEPTH];
  logic                   q_last  [Q_DEPTH];
  logic [HEAD_ADDR_W-1:0] q_addr  [Q_DEPTH];
  logic [LEN_W-1:0]       q_len   [Q_DEPTH];
  logic [LEN_W-1:0]       q_beats [Q_DEPTH];

  logic [Q_AW-1:0] wr_ptr_reg;
  logic [Q_AW-1:0] rd_ptr_reg;
  logic [Q_AW:0]   q_cnt_reg;

  fwd_state_e state_reg;
  fwd_state_e state_next;
  logic       load;

  logic [TAG_W-1:0]       cur_tag_reg;
  logic [CHNL_W-1:0]      cur_chnl_reg;
  logic                   cur_last_reg;
  logic [HEAD_ADDR_W-1:0] cur_addr_reg;
  logic [LEN_W-1:0]       cur_len_reg;
  logic [LEN_W-1:0]       cur_exp_reg;
  logic [LEN_W-1:0]       beat_cnt_reg;
  logic [LEN_W-1:0]       beat_cnt_inc;
  logic                   beat_err_reg;

  logic [LEN_W-1:0] enq_bytes;
  logic [LEN_W-1:0] enq_len;
  logic [LEN_W-1:0] enq_beats;
  logic             enq;
  logic             xfer;
  logic             final_xfer;
  logic             skid_full;
  logic [HEAD_W-1:0]    beat_head;
  logic [PAYLOAD_W-1:0] skid_out;
  logic                 unused_chnl_hi;

  // Only the low channel bits travel in the head
  assign unused_chnl_hi = ^cur_chnl_reg[CHNL_W-1:HEAD_CHNL_W];

  assign nxt_match_ready = (q_cnt_reg != (Q_AW+1)'(Q_DEPTH));
  assign enq             = nxt_match_valid & nxt_match_ready;
  assign ft_rd_rsp_ren   = (state_reg == ST_FORWARD) & ~skid_full;
  assign ft_rd_rsp_tag   = (state_reg == ST_FORWARD) ? cur_tag_reg : '0;
  assign xfer            = ft_rd_rsp_ren & ft_rd_rsp_vld;
  assign final_xfer      = xfer & ft_rd_rsp_last;
  assign beat_cnt_inc    = beat_cnt_reg + LEN_W'(1);
  assign beat_err        = beat_err_reg;

  // Byte length and expected beat count of the incoming descriptor
  always_comb begin
    enq_bytes = (nxt_match_sz == '0) ? LEN_W'(MAX_BYTES) : (LEN_W'(nxt_match_sz) << 2);
    enq_len   = enq_bytes - LEN_W'(nxt_match_misc[MISC_EMPTY_W-1:0]);
    enq_beats = (enq_bytes + LEN_W'(BEAT_BYTES - 1)) >> BEAT_SH;
  end

  // Write accepted descriptors into the queue slot at the write pointer
  always_ff @(posedge dma_clk) begin
    if (enq) begin
      q_tag[wr_ptr_reg]   <= nxt_match_tag;
      q_chnl[wr_ptr_reg]  <= nxt_match_chnl;
      q_last[wr_ptr_reg]  <= nxt_match_last;
      q_addr[wr_ptr_reg]  <= nxt_match_misc[MISC_ADDR_LSB +: HEAD_ADDR_W];
      q_len[wr_ptr_reg]   <= enq_len;
      q_beats[wr_ptr_reg] <= enq_beats;
    end
  end

  // Queue pointers wrap naturally; a simultaneous push and pop keeps the count
  always_ff @(posedge dma_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      q_cnt_reg  <= '0;
    end else begin
      if (enq)  wr_ptr_reg <= wr_ptr_reg + Q_AW'(1);
      if (load) rd_ptr_reg <= rd_ptr_reg + Q_AW'(1);
      case ({enq, load})
        2'b10:   q_cnt_reg <= q_cnt_reg + (Q_AW+1)'(1);
        2'b01:   q_cnt_reg <= q_cnt_reg - (Q_AW+1)'(1);
        default: q_cnt_reg <= q_cnt_reg;
      endcase
    end
  end

  // Next state: load a descriptor from IDLE, or chain straight into the next
  // one on the final beat so back-to-back tags see no bubble
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (q_cnt_reg != '0) begin
          load       = 1'b1;
          state_next = ST_FORWARD;
        end
      end
      ST_FORWARD: begin
        if (final_xfer) begin
          if (q_cnt_reg != '0) begin
            load = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge dma_clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Current-descriptor registers, beat counter and beat-count error pulse
  always_ff @(posedge dma_clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_tag_reg  <= '0;
      cur_chnl_reg <= '0;
      cur_last_reg <= 1'b0;
      cur_addr_reg <= '0;
      cur_len_reg  <= '0;
      cur_exp_reg  <= '0;
      beat_cnt_reg <= '0;
      beat_err_reg <= 1'b0;
    end else begin
      beat_err_reg <= xfer & ((ft_rd_rsp_last & (beat_cnt_inc != cur_exp_reg)) |
                              (~ft_rd_rsp_last & (beat_cnt_inc == cur_exp_reg)));
      if (load) begin
        cur_tag_reg  <= q_tag[rd_ptr_reg];
        cur_chnl_reg <= q_chnl[rd_ptr_reg];
        cur_last_reg <= q_last[rd_ptr_reg];
        cur_addr_reg <= q_addr[rd_ptr_reg];
        cur_len_reg  <= q_len[rd_ptr_reg];
        cur_exp_reg  <= q_beats[rd_ptr_reg];
        beat_cnt_reg <= '0;
      end else if (xfer) begin
        beat_cnt_reg <= beat_cnt_inc;
      end
    end
  end

  // Head word attached to every beat of the current descriptor
  always_comb begin
    beat_head = '0;
    beat_head[HEAD_W-HEAD_LAST_OFS]                 = cur_last_reg;
    beat_head[HEAD_W-HEAD_CHNL_OFS -: HEAD_CHNL_W]  = cur_chnl_reg[HEAD_CHNL_W-1:0];
    beat_head[HEAD_ADDR_LSB +: HEAD_ADDR_W]         = cur_addr_reg;
    beat_head[HEAD_LEN_LSB +: LEN_W]                = cur_len_reg;
  end

  sub_req_rsp_skid #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_skid (
    .dma_clk      (dma_clk),
    .rst_n        (rst_n),
    .push_valid   (xfer),
    .push_payload ({ft_rd_rsp_last, beat_head, ft_rd_rsp_data}),
    .full         (skid_full),
    .pop_valid    (st_sub_req_rsp_valid),
    .pop_payload  (skid_out),
    .pop_ready    (st_sub_req_rsp_ready)
  );

  assign st_sub_req_rsp_last = skid_out[PAYLOAD_W-1];
  assign st_sub_req_rsp_head = skid_out[DATA_W +: HEAD_W];
  assign st_sub_req_rsp_data = skid_out[DATA_W-1:0];

endmodule

// File: tb/tb_sub_req_rsp_fwd.sv
// Scoreboard bench for sub_req_rsp_fwd: a reorder-buffer model answers the
// tag fetches, expected output beats are queued as beats are driven and
// compared as the output stage hands them over.
module tb_sub_req_rsp_fwd;

  localparam int DATA_W = 256;
  localparam int HEAD_W = 128;
  localparam int TAG_W  = 6;

  typedef struct {
    logic [5:0]  tag;
    logic [7:0]  chnl;
    logic        last;
    logic [10:0] sz;
    logic [11:0] misc;
    int          nbeats;
  } desc_t;

  typedef struct {
    logic [255:0] data;
    logic [127:0] head;
    logic         last;
  } beat_t;

  logic               dma_clk;
  logic               rst_n;
  logic               ft_rd_rsp_ren;
  logic [TAG_W-1:0]   ft_rd_rsp_tag;
  logic [DATA_W-1:0]  ft_rd_rsp_data;
  logic               ft_rd_rsp_last;
  logic               ft_rd_rsp_vld;
  logic               nxt_match_valid;
  logic               nxt_match_ready;
  logic               nxt_match_last;
  logic [10:0]        nxt_match_sz;
  logic [11:0]        nxt_match_misc;
  logic [7:0]         nxt_match_chnl;
  logic [TAG_W-1:0]   nxt_match_tag;
  logic               st_sub_req_rsp_valid;
  logic               st_sub_req_rsp_last;
  logic [DATA_W-1:0]  st_sub_req_rsp_data;
  logic [HEAD_W-1:0]  st_sub_req_rsp_head;
  logic               st_sub_req_rsp_ready;
  logic               beat_err;

  sub_req_rsp_fwd dut (
    .dma_clk              (dma_clk),
    .rst_n                (rst_n),
    .ft_rd_rsp_ren        (ft_rd_rsp_ren),
    .ft_rd_rsp_tag        (ft_rd_rsp_tag),
    .ft_rd_rsp_data       (ft_rd_rsp_data),
    .ft_rd_rsp_last       (ft_rd_rsp_last),
    .ft_rd_rsp_vld        (ft_rd_rsp_vld),
    .nxt_match_valid      (nxt_match_valid),
    .nxt_match_ready      (nxt_match_ready),
    .nxt_match_last       (nxt_match_last),
    .nxt_match_sz         (nxt_match_sz),
    .nxt_match_misc       (nxt_match_misc),
    .nxt_match_chnl       (nxt_match_chnl),
    .nxt_match_tag        (nxt_match_tag),
    .st_sub_req_rsp_valid (st_sub_req_rsp_valid),
    .st_sub_req_rsp_last  (st_sub_req_rsp_last),
    .st_sub_req_rsp_data  (st_sub_req_rsp_data),
    .st_sub_req_rsp_head  (st_sub_req_rsp_head),
    .st_sub_req_rsp_ready (st_sub_req_rsp_ready),
    .beat_err             (beat_err)
  );

  initial begin
    dma_clk = 1'b0;
    forever #5 dma_clk = ~dma_clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  desc_t pending[$];
  beat_t sb[$];
  int    pop_cycles[$];

  int  cyc         = 0;
  int  occ         = 0;
  int  bidx        = 0;
  int  out_cnt     = 0;
  int  beats_total = 0;
  int  err_pulses  = 0;
  int  full_seen   = 0;
  bit  xfer_q      = 0;
  bit  pop_q       = 0;
  bit  err_q       = 0;
  bit  hold_q      = 0;
  bit  src_en      = 0;
  bit  ready_mode  = 0;
  bit  tgl         = 1;
  logic [255:0] held_data;
  logic [127:0] held_head;
  logic         held_last;
  logic [127:0] last_head;
  beat_t        mon_beat;
  beat_t        exp_beat;
  desc_t        mon_desc;

  task automatic check_eq(input string name, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int desc_bytes(input desc_t d);
    return (d.sz == 0) ? 4096 : int'(d.sz) * 4;
  endfunction

  function automatic logic [127:0] exp_head(input desc_t d);
    logic [127:0] h;
    int len;
    len = desc_bytes(d) - int'(d.misc[4:0]);
    h = '0;
    h[127]     = d.last;
    h[126:120] = d.chnl[6:0];
    h[38:32]   = d.misc[11:5];
    h[12:0]    = len[12:0];
    return h;
  endfunction

  // Per-cycle model: output checks, downstream ready, reorder-buffer source
  always @(negedge dma_clk) begin
    cyc++;
    if (!rst_n) begin
      sb.delete();
      pending.delete();
      occ = 0; xfer_q = 0; pop_q = 0; err_q = 0; hold_q = 0; bidx = 0;
      ft_rd_rsp_vld = 1'b0;
      ft_rd_rsp_last = 1'b0;
    end else begin
      occ = occ + (xfer_q ? 1 : 0) - (pop_q ? 1 : 0);
      check_eq("st_valid", st_sub_req_rsp_valid, occ != 0);
      check_eq("beat_err", beat_err, err_q);
      if (beat_err) err_pulses++;
      if (occ == 2) begin
        full_seen++;
        check_eq("ren_when_full", ft_rd_rsp_ren, 0);
      end
      if (hold_q) begin
        check_eq("stall_data", st_sub_req_rsp_data, held_data);
        check_eq("stall_head", st_sub_req_rsp_head, held_head);
        check_eq("stall_last", st_sub_req_rsp_last, held_last);
      end
      tgl = ready_mode ? ~tgl : 1'b1;
      st_sub_req_rsp_ready = tgl;
      pop_q = st_sub_req_rsp_valid && st_sub_req_rsp_ready;
      if (pop_q) begin
        if (sb.size() == 0) begin
          check_eq("sb_extra_beat", st_sub_req_rsp_valid, 0);
        end else begin
          exp_beat = sb.pop_front();
          check_eq("out_data", st_sub_req_rsp_data, exp_beat.data);
          check_eq("out_head", st_sub_req_rsp_head, exp_beat.head);
          check_eq("out_last", st_sub_req_rsp_last, exp_beat.last);
          out_cnt++;
          pop_cycles.push_back(cyc);
          last_head = st_sub_req_rsp_head;
        end
      end
      hold_q    = st_sub_req_rsp_valid && !st_sub_req_rsp_ready;
      held_data = st_sub_req_rsp_data;
      held_head = st_sub_req_rsp_head;
      held_last = st_sub_req_rsp_last;
      xfer_q = 0;
      err_q  = 0;
      if (ft_rd_rsp_ren && src_en && pending.size() != 0) begin
        mon_desc = pending[0];
        check_eq("fetch_tag", ft_rd_rsp_tag, mon_desc.tag);
        for (int i = 0; i < 8; i++) mon_beat.data[i*32 +: 32] = $urandom;
        mon_beat.last = (bidx == mon_desc.nbeats - 1);
        mon_beat.head = exp_head(mon_desc);
        ft_rd_rsp_data = mon_beat.data;
        ft_rd_rsp_last = mon_beat.last;
        ft_rd_rsp_vld  = 1'b1;
        sb.push_back(mon_beat);
        err_q = (mon_beat.last && (bidx + 1 != (desc_bytes(mon_desc) + 31) / 32)) ||
                (!mon_beat.last && (bidx + 1 == (desc_bytes(mon_desc) + 31) / 32));
        xfer_q = 1;
        beats_total++;
        bidx++;
        if (mon_beat.last) begin
          void'(pending.pop_front());
          bidx = 0;
        end
      end else begin
        ft_rd_rsp_vld  = 1'b0;
        ft_rd_rsp_last = 1'b0;
      end
    end
  end

  // Offer one descriptor; caller sits just after a rising edge
  task automatic enq(input logic [10:0] sz, input logic [11:0] misc, input logic [7:0] chnl,
                     input logic [5:0] tag, input logic last, input int nbeats);
    desc_t d;
    int guard;
    d.sz = sz; d.misc = misc; d.chnl = chnl; d.tag = tag; d.last = last; d.nbeats = nbeats;
    nxt_match_valid = 1'b1;
    nxt_match_sz = sz; nxt_match_misc = misc; nxt_match_chnl = chnl;
    nxt_match_tag = tag; nxt_match_last = last;
    guard = 0;
    while (!nxt_match_ready && guard < 1000) begin
      @(posedge dma_clk); #1;
      guard++;
    end
    if (!nxt_match_ready) begin
      check_eq("enq_timeout", nxt_match_ready, 1);
    end else begin
      pending.push_back(d);
      @(posedge dma_clk); #1;
    end
    nxt_match_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((pending.size() != 0 || sb.size() != 0) && guard < 2000) begin
      @(posedge dma_clk); #1;
      guard++;
    end
    check_eq("drain_done", (pending.size() == 0 && sb.size() == 0), 1);
    @(posedge dma_clk); #1;
  endtask

  task automatic check_quiet(input string name);
    check_eq({name, "_valid"}, st_sub_req_rsp_valid, 0);
    check_eq({name, "_ren"},   ft_rd_rsp_ren, 0);
    check_eq({name, "_tag"},   ft_rd_rsp_tag, 0);
    check_eq({name, "_err"},   beat_err, 0);
    check_eq({name, "_data"},  st_sub_req_rsp_data, 0);
    check_eq({name, "_head"},  st_sub_req_rsp_head, 0);
    check_eq({name, "_last"},  st_sub_req_rsp_last, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base;
  int guard;

  initial begin
    rst_n = 1'b0;
    ft_rd_rsp_vld = 1'b0; ft_rd_rsp_last = 1'b0; ft_rd_rsp_data = '0;
    nxt_match_valid = 1'b0; nxt_match_last = 1'b0; nxt_match_sz = '0;
    nxt_match_misc = '0; nxt_match_chnl = '0; nxt_match_tag = '0;
    st_sub_req_rsp_ready = 1'b1;
    #1;
    check_quiet("reset");
    repeat (3) @(posedge dma_clk);
    #1 rst_n = 1'b1;
    @(posedge dma_clk); #1;
    check_eq("rst_ready", nxt_match_ready, 1);

    // Single 2-beat descriptor: byte_len 64, addr 5, chnl 3, last-of-request
    src_en = 1; base = out_cnt;
    enq(11'd16, {7'd5, 5'd0}, 8'd3, 6'd1, 1'b1, 2);
    wait_drain();
    check_eq("t1_beats", out_cnt - base, 2);
    check_eq("t1_len", last_head[12:0], 64);

    // Four single-beat descriptors back-to-back
    src_en = 0; pop_cycles.delete(); base = out_cnt;
    for (int i = 0; i < 4; i++)
      enq(11'd8, {7'(i + 1), 5'd0}, 8'(i + 8), 6'(10 + i), (i == 3), 1);
    src_en = 1;
    wait_drain();
    check_eq("t2_beats", out_cnt - base, 4);
    if (pop_cycles.size() == 4)
      check_eq("t2_no_bubble", pop_cycles[3] - pop_cycles[0], 3);

    // Queue full: one descriptor in flight plus Q_DEPTH waiting
    src_en = 0;
    for (int i = 0; i < 5; i++)
      enq(11'd8, {7'd2, 5'd4}, 8'd1, 6'(20 + i), 1'b0, 1);
    check_eq("q_full_ready", nxt_match_ready, 0);
    src_en = 1;
    @(posedge dma_clk); #1;
    check_eq("q_ready_after_tag", nxt_match_ready, 1);
    wait_drain();

    // Downstream ready toggling over an 8-beat tag
    ready_mode = 1; full_seen = 0; base = out_cnt;
    enq(11'd64, {7'd9, 5'd1}, 8'd77, 6'd33, 1'b1, 8);
    wait_drain();
    check_eq("t4_beats", out_cnt - base, 8);
    check_eq("t4_skid_full_seen", full_seen > 0, 1);
    ready_mode = 0;

    // Early last: 2 beats expected, only 1 returned
    base = err_pulses;
    enq(11'd16, {7'd3, 5'd0}, 8'd4, 6'd9, 1'b0, 1);
    wait_drain();
    repeat (2) @(posedge dma_clk);
    #1;
    check_eq("t5_err_once", err_pulses - base, 1);
    check_eq("t5_idle_ren", ft_rd_rsp_ren, 0);
    check_eq("t5_idle_tag", ft_rd_rsp_tag, 0);

    // 1024-DW request with 3 empty bytes, reset after the third beat
    base = beats_total;
    enq(11'd0, {7'd6, 5'd3}, 8'd5, 6'd5, 1'b0, 128);
    guard = 0;
    while (beats_total < base + 3 && guard < 200) begin
      @(posedge dma_clk); #1;
      guard++;
    end
    check_eq("t6_three_beats", beats_total >= base + 3, 1);
    check_eq("t6_len", last_head[12:0], 4093);
    rst_n = 1'b0;
    #1;
    check_quiet("midreset");
    repeat (2) @(posedge dma_clk);
    #1 rst_n = 1'b1;
    @(posedge dma_clk); #1;
    check_eq("t6_ready", nxt_match_ready, 1);
    check_quiet("post_reset");
    repeat (5) @(posedge dma_clk);
    #1;
    check_eq("t6_no_output", st_sub_req_rsp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
